// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS front end: fetch FSM encoding, reset constants
// and the word-alignment helper used for redirect targets.
package cpu_pkg;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_DROP  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] INSTR_NOP        = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/Add4.sv
// Constant +4 adder shared by the PC path; wraps modulo 2^32.
module Add4 (
  input  logic [31:0] a,
  output logic [31:0] y
);

  assign y = a + 32'd4;

endmodule

// File: rtl/pc_fetch_unit.sv
// Holds the architectural PC, issues fetches over a req/ready handshake and
// presents one instruction at a time to decode with stall and redirect support.
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        branchTaken,
  input  logic [31:0] branchTarget,
  input  logic        jump,
  input  logic [31:0] jumpTarget,
  input  logic        stall,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemReady,
  input  logic [31:0] imemData,
  output logic        instrValid,
  output logic [31:0] instr,
  output logic [31:0] instrPC,
  output logic [31:0] pcPlus4
);

  fetch_state_t state_r, state_s;
  logic [31:0]  pc_r, pc_s;
  logic [31:0]  drop_addr_r, drop_addr_s;
  logic [31:0]  instr_r, instr_s;
  logic [31:0]  instr_pc_r, instr_pc_s;
  logic         instr_valid_r, instr_valid_s;
  logic         pending_r, pending_s;

  logic [31:0]  pc_plus4_s;
  logic         consume_s;
  logic         slot_free_s;
  logic         redirect_s;
  logic [31:0]  target_s;
  logic         imem_req_s;
  logic         transfer_s;

  Add4 u_add4 (
    .a (pc_r),
    .y (pc_plus4_s)
  );

  assign consume_s   = instr_valid_r && !stall;
  assign slot_free_s = !instr_valid_r || consume_s;
  assign redirect_s  = jump || branchTaken;
  assign target_s    = word_align(jump ? jumpTarget : branchTarget);
  assign transfer_s  = imem_req_s && imemReady;

  // Request generation: a request left unanswered stays asserted regardless of stall.
  always_comb begin
    imem_req_s = 1'b0;
    case (state_r)
      S_BOOT:  imem_req_s = 1'b0;
      S_FETCH: imem_req_s = slot_free_s || pending_r;
      S_DROP:  imem_req_s = 1'b1;
      default: imem_req_s = 1'b0;
    endcase
  end

  // Next-state, PC and instruction-slot update.
  always_comb begin
    state_s       = state_r;
    pc_s          = pc_r;
    drop_addr_s   = drop_addr_r;
    instr_s       = instr_r;
    instr_pc_s    = instr_pc_r;
    instr_valid_s = instr_valid_r;
    pending_s     = 1'b0;
    case (state_r)
      S_BOOT: begin
        state_s = S_FETCH;
        if (redirect_s) begin
          pc_s = target_s;
        end else begin
          pc_s = pc_r;
        end
      end
      S_FETCH: begin
        if (redirect_s) begin
          pc_s          = target_s;
          instr_valid_s = 1'b0;
          // An unanswered request must be completed at its old address and thrown away.
          if (imem_req_s && !imemReady) begin
            state_s     = S_DROP;
            drop_addr_s = pc_r;
          end else begin
            state_s = S_FETCH;
          end
        end else if (transfer_s) begin
          instr_s       = imemData;
          instr_pc_s    = pc_r;
          instr_valid_s = 1'b1;
          pc_s          = pc_plus4_s;
        end else begin
          pending_s = imem_req_s;
          if (consume_s) begin
            instr_valid_s = 1'b0;
          end else begin
            instr_valid_s = instr_valid_r;
          end
        end
      end
      S_DROP: begin
        if (redirect_s) begin
          pc_s          = target_s;
          instr_valid_s = 1'b0;
        end else if (consume_s) begin
          instr_valid_s = 1'b0;
        end else begin
          instr_valid_s = instr_valid_r;
        end
        if (imemReady) begin
          state_s = S_FETCH;
        end else begin
          state_s = S_DROP;
        end
      end
      default: begin
        state_s       = S_BOOT;
        instr_valid_s = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= S_BOOT;
      pc_r          <= RESET_PC;
      drop_addr_r   <= 32'h0000_0000;
      instr_r       <= INSTR_NOP;
      instr_pc_r    <= 32'h0000_0000;
      instr_valid_r <= 1'b0;
      pending_r     <= 1'b0;
    end else begin
      state_r       <= state_s;
      pc_r          <= pc_s;
      drop_addr_r   <= drop_addr_s;
      instr_r       <= instr_s;
      instr_pc_r    <= instr_pc_s;
      instr_valid_r <= instr_valid_s;
      pending_r     <= pending_s;
    end
  end

  assign imemReq    = imem_req_s;
  assign imemAddr   = (state_r == S_DROP) ? drop_addr_r : pc_r;
  assign instrValid = instr_valid_r;
  assign instr      = instr_r;
  assign instrPC    = instr_pc_r;
  assign pcPlus4    = pc_plus4_s;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed table-driven bench for pc_fetch_unit plus a hand-written async reset sequence.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        branchTaken;
  logic [31:0] branchTarget;
  logic        jump;
  logic [31:0] jumpTarget;
  logic        stall;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemReady;
  logic [31:0] imemData;
  logic        instrValid;
  logic [31:0] instr;
  logic [31:0] instrPC;
  logic [31:0] pcPlus4;

  int n_vec = 0;
  int n_err = 0;

  pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .reset        (reset),
    .branchTaken  (branchTaken),
    .branchTarget (branchTarget),
    .jump         (jump),
    .jumpTarget   (jumpTarget),
    .stall        (stall),
    .imemReq      (imemReq),
    .imemAddr     (imemAddr),
    .imemReady    (imemReady),
    .imemData     (imemData),
    .instrValid   (instrValid),
    .instr        (instr),
    .instrPC      (instrPC),
    .pcPlus4      (pcPlus4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        br;
    logic [31:0] bt;
    logic        jp;
    logic [31:0] jt;
    logic        st;
    logic        rdy;
    logic [31:0] data;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_v;
    logic [31:0] e_instr;
    logic [31:0] e_ipc;
    logic [31:0] e_pc4;
  } vec_t;

  localparam int NV = 23;
  localparam logic [31:0] Z    = 32'h0000_0000;
  localparam logic [31:0] D0   = 32'h1111_0000;
  localparam logic [31:0] D4   = 32'h1111_0004;
  localparam logic [31:0] D8   = 32'h1111_0008;
  localparam logic [31:0] DC   = 32'h1111_000C;
  localparam logic [31:0] D40  = 32'h1111_0040;
  localparam logic [31:0] D100 = 32'h1111_0100;
  localparam logic [31:0] DF   = 32'h2222_FFFC;
  localparam logic [31:0] XX   = 32'hBAD0_0000;
  localparam logic [31:0] TOP  = 32'hFFFF_FFFC;

  vec_t vecs [NV];

  task automatic check(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s row %0d: got %h want %h", name, row, act, exp);
    end
  endtask

  task automatic check_all(input int row, input logic e_req, input logic [31:0] e_addr, input logic e_v,
                           input logic [31:0] e_instr, input logic [31:0] e_ipc, input logic [31:0] e_pc4);
    n_vec = n_vec + 1;
    check("imemReq",    row, {31'd0, imemReq},    {31'd0, e_req});
    check("imemAddr",   row, imemAddr,            e_addr);
    check("instrValid", row, {31'd0, instrValid}, {31'd0, e_v});
    check("instr",      row, instr,               e_instr);
    check("instrPC",    row, instrPC,             e_ipc);
    check("pcPlus4",    row, pcPlus4,             e_pc4);
  endtask

  initial begin
    // Columns: br bt jp jt st rdy data | req addr valid instr instrPC pcPlus4
    vecs[0]  = '{1'b0, Z, 1'b0, Z, 1'b0, 1'b1, Z,      1'b0, Z,            1'b0, Z,    Z,            32'h4};
    vecs[1]  = '{1'b0, Z, 1'b0, Z, 1'b0, 1'b1, D0,     1'b1, Z,            1'b0, Z,    Z,            32'h4};
    vecs[2]  = '{1'b0, Z, 1'b0, Z, 1'b0, 1'b1, D4,     1'b1, 32'h4,        1'b1, D0,   Z,            32'h8};
    vecs[3]  = '{1'b0, Z, 1'b0, Z, 1'b1, 1'b1, XX,     1'b0, 32'h8,        1'b1, D4,   32'h4,        32'hC};
    vecs[4]  = '{1'b0, Z, 1'b0, Z, 1'b1, 1'b1, XX,     1'b0, 32'h8,        1'b1, D4,   32'h4,        32'hC};
    vecs[5]  = '{1'b0, Z, 1'b0, Z, 1'b1, 1'b1, XX,     1'b0, 32'h8,        1'b1, D4,   32'h4,        32'hC};
    vecs[6]  = '{1'b0, Z, 1'b0, Z, 1'b0, 1'b1, D8,     1'b1, 32'h8,        1'b1, D4,   32'h4,        32'hC};
    vecs[7]  = '{1'b0, Z, 1'b0, Z, 1'b0, 1'b0, XX,     1'b1, 32'hC,        1'b1, D8,   32'h8,        32'h10};
    vecs[8]  = '{1'b0, Z, 1'b0, Z, 1'b1, 1'b0, XX,     1'b1, 32'hC,        1'b0, D8,   32'h8,        32'h10};
    vecs[9]  = '{1'b0, Z, 1'b0, Z, 1'b0, 1'b1, DC,     1'b1, 32'hC,        1'b0, D8,   32'h8,        32'h10};
    vecs[10] = '{1'b0, Z, 1'b0, Z, 1'b0, 1'b0, XX,     1'b1, 32'h10,       1'b1, DC,   32'hC,        32'h14};
    vecs[11] = '{1'b1, 32'h40, 1'b0, Z, 1'b0, 1'b0, XX, 1'b1, 32'h10,      1'b0, DC,   32'hC,        32'h14};
    vecs[12] = '{1'b0, Z, 1'b0, Z, 1'b0, 1'b0, XX,     1'b1, 32'h10,       1'b0, DC,   32'hC,        32'h44};
    vecs[13] = '{1'b0, Z, 1'b0, Z, 1'b0, 1'b1, 32'hDEAD_0010, 1'b1, 32'h10, 1'b0, DC,  32'hC,        32'h44};
    vecs[14] = '{1'b1, 32'h200, 1'b1, 32'h100, 1'b0, 1'b1, D40, 1'b1, 32'h40, 1'b0, DC, 32'hC,       32'h44};
    vecs[15] = '{1'b0, Z, 1'b0, Z, 1'b0, 1'b1, D100,   1'b1, 32'h100,      1'b0, DC,   32'hC,        32'h104};
    vecs[16] = '{1'b0, Z, 1'b1, TOP, 1'b1, 1'b0, XX,   1'b0, 32'h104,      1'b1, D100, 32'h100,      32'h108};
    vecs[17] = '{1'b0, Z, 1'b0, Z, 1'b0, 1'b1, DF,     1'b1, TOP,          1'b0, D100, 32'h100,      Z};
    vecs[18] = '{1'b1, 32'h43, 1'b0, Z, 1'b0, 1'b1, 32'h3333_0000, 1'b1, Z, 1'b1, DF,  TOP,          32'h4};
    vecs[19] = '{1'b0, Z, 1'b0, Z, 1'b0, 1'b1, D40,    1'b1, 32'h40,       1'b0, DF,   TOP,          32'h44};
    vecs[20] = '{1'b0, Z, 1'b0, Z, 1'b0, 1'b0, XX,     1'b1, 32'h44,       1'b1, D40,  32'h40,       32'h48};
    vecs[21] = '{1'b1, 32'h80, 1'b0, Z, 1'b0, 1'b0, XX, 1'b1, 32'h44,      1'b0, D40,  32'h40,       32'h48};
    vecs[22] = '{1'b0, Z, 1'b1, 32'h200, 1'b0, 1'b0, XX, 1'b1, 32'h44,     1'b0, D40,  32'h40,       32'h84};

    branchTaken  = 1'b0;
    branchTarget = Z;
    jump         = 1'b0;
    jumpTarget   = Z;
    stall        = 1'b0;
    imemReady    = 1'b0;
    imemData     = Z;
    reset        = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all(-1, 1'b0, Z, 1'b0, Z, Z, 32'h4);

    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < NV; i++) begin
      branchTaken  = vecs[i].br;
      branchTarget = vecs[i].bt;
      jump         = vecs[i].jp;
      jumpTarget   = vecs[i].jt;
      stall        = vecs[i].st;
      imemReady    = vecs[i].rdy;
      imemData     = vecs[i].data;
      #1;
      check_all(i, vecs[i].e_req, vecs[i].e_addr, vecs[i].e_v, vecs[i].e_instr, vecs[i].e_ipc, vecs[i].e_pc4);
      @(negedge clk);
    end

    // Now in S_DROP with dropAddr 0x44 and pc 0x200; reset mid-cycle without any clock edge.
    branchTaken = 1'b0;
    jump        = 1'b0;
    stall       = 1'b0;
    imemReady   = 1'b0;
    #1;
    check_all(100, 1'b1, 32'h44, 1'b0, D40, 32'h40, 32'h204);
    #2;
    reset = 1'b1;
    #1;
    check_all(101, 1'b0, Z, 1'b0, Z, Z, 32'h4);

    @(negedge clk);
    reset     = 1'b0;
    imemReady = 1'b1;
    imemData  = D0;
    #1;
    check_all(102, 1'b0, Z, 1'b0, Z, Z, 32'h4);
    @(negedge clk);
    #1;
    check_all(103, 1'b1, Z, 1'b0, Z, Z, 32'h4);
    @(negedge clk);
    imemData = D4;
    #1;
    check_all(104, 1'b1, 32'h4, 1'b1, D0, Z, 32'h8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
